// File: rtl/raised_cosine_filter.sv
// raised_cosine_filter: 17-tap symmetric raised-cosine pulse-shaping FIR.
// The filter uses roll-off 0.5, 4 samples/symbol and a 4-symbol span, with the peak coefficient scaled to 0.5.
// Ports:
//   clk        rising-edge system clock
//   reset      asynchronous active-low reset; clears the delay line and the output
//   clk_enable sample valid; the delay line and the output advance only when this is 1
//   In1        signed int16 input sample
//   ce_out     combinational copy of clk_enable
//   Out1       registered signed int16 output: floor(acc / 2^15), saturated to int16
module raised_cosine_filter #(
    parameter int NTAPS = 17,
    parameter int DW    = 16,
    parameter int CW    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clk_enable,
    input  logic signed [DW-1:0] In1,
    output logic                 ce_out,
    output logic signed [DW-1:0] Out1
);
    // Wide enough that 17 full-scale products never wrap.
    localparam int AW    = 38;
    localparam int HALF  = NTAPS / 2;
    localparam int SHIFT = CW - 1;

    // Only the unique half of the symmetric set is stored: c[k] = c[NTAPS-1-k].
    localparam logic signed [CW-1:0] COEF [0:HALF] = '{
        16'sd0, -16'sd944, -16'sd1966, -16'sd2007, 16'sd0,
        16'sd4301, 16'sd9833, 16'sd14536, 16'sd16384
    };

    // The oldest stored sample (x[16]) never reaches the sum, so it is not kept.
    logic signed [DW-1:0] x    [0:NTAPS-2];
    logic signed [DW-1:0] tap  [0:NTAPS-1];
    logic signed [AW-1:0] pre  [0:HALF];
    logic signed [AW-1:0] acc;
    logic        [AW-SHIFT-1:0] scaled;
    logic                 fits;
    logic signed [DW-1:0] sat;

    assign ce_out = clk_enable;

    // Taps of the post-shift delay line: the new sample sits at tap 0.
    always_comb begin
        tap[0] = In1;
        for (int i = 1; i < NTAPS; i++) tap[i] = x[i-1];
    end

    // Pre-add mirrored taps so that only HALF+1 multiplies are needed.
    always_comb begin
        acc = '0;
        for (int k = 0; k < HALF; k++) begin
            pre[k] = AW'(tap[k]) + AW'(tap[NTAPS-1-k]);
            acc    = acc + pre[k] * AW'(COEF[k]);
        end
        pre[HALF] = AW'(tap[HALF]);
        acc       = acc + pre[HALF] * AW'(COEF[HALF]);
    end

    // Dropping the low bits of a two's-complement value gives floor division.
    // The result fits int16 when every bit above the sign bit matches it.
    always_comb begin
        scaled = acc[AW-1:SHIFT];
        fits   = (&scaled[AW-SHIFT-1:DW-1]) | ~(|scaled[AW-SHIFT-1:DW-1]);
        sat    = fits ? scaled[DW-1:0]
                      : (scaled[AW-SHIFT-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}});
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NTAPS-1; i++) x[i] <= '0;
            Out1 <= '0;
        end else if (clk_enable) begin
            x[0] <= In1;
            for (int i = 1; i < NTAPS-1; i++) x[i] <= x[i-1];
            Out1 <= sat;
        end
    end
endmodule

// File: tb/tb_raised_cosine_filter.sv
// tb_raised_cosine_filter: self-checking bench for raised_cosine_filter.
// It combines vector tables, directed corner cases and a random run checked against a behavioural model.
module tb_raised_cosine_filter;
    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               clk_enable = 1'b0;
    logic signed [15:0] In1 = '0;
    logic               ce_out;
    logic signed [15:0] Out1;

    int checks = 0;
    int failures = 0;

    raised_cosine_filter dut (
        .clk(clk), .reset(reset), .clk_enable(clk_enable),
        .In1(In1), .ce_out(ce_out), .Out1(Out1)
    );

    always #5 clk = ~clk;

    // Behavioural reference: the full 17-entry sample history, with the newest sample first.
    int  coef [17] = '{0, -944, -1966, -2007, 0, 4301, 9833, 14536, 16384,
                       14536, 9833, 4301, 0, -2007, -1966, -944, 0};
    int  hist [17];
    int  model_out = 0;

    task automatic model_clear();
        for (int i = 0; i < 17; i++) hist[i] = 0;
        model_out = 0;
    endtask

    task automatic model_push(input int s);
        longint acc = 0;
        longint q;
        for (int i = 16; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = s;
        for (int i = 0; i < 17; i++) acc += longint'(coef[i]) * longint'(hist[i]);
        q = acc >>> 15;
        model_out = (q > 32767) ? 32767 : (q < -32768) ? -32768 : int'(q);
    endtask

    task automatic chk(input string name, input logic signed [15:0] act, input int exp);
        checks++;
        if (act !== 16'(exp)) begin
            failures++;
            $display("FAIL %s: Out1 got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_ce(input string name);
        checks++;
        if (ce_out !== clk_enable) begin
            failures++;
            $display("FAIL %s: ce_out got %b expected %b", name, ce_out, clk_enable);
        end
    endtask

    // One clock: drive on the falling edge, then sample 1 time unit after the rising edge.
    task automatic step(input bit en, input logic signed [15:0] din);
        @(negedge clk);
        clk_enable = en;
        In1 = din;
        @(posedge clk);
        #1;
        if (en) model_push(int'(din));
        chk("model", Out1, model_out);
        chk_ce("ce_track");
    endtask

    typedef struct {
        bit                 en;
        logic signed [15:0] din;
        int                 exp;
    } vec_t;

    vec_t tbl [24];
    int   imp [17] = '{0, -944, -1966, -2007, 0, 4300, 9832, 14535, 16383,
                       14535, 9832, 4300, 0, -2007, -1966, -944, 0};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        n = 0;
        // Impulse response, with the enable dropped for 3 cycles after the 7th output.
        for (int i = 0; i < 17; i++) begin
            tbl[n] = '{1'b1, (i == 0) ? 16'sd32767 : 16'sd0, imp[i]};
            n++;
            if (i == 6)
                for (int j = 0; j < 3; j++) begin
                    tbl[n] = '{1'b0, 16'sh5a5a, imp[6]};
                    n++;
                end
        end
        for (int i = 0; i < 4; i++) begin
            tbl[n] = '{1'b1, 16'sd0, 0};
            n++;
        end

        model_clear();
        // Check reset: Out1 is held at 0, and ce_out follows clk_enable even while reset is low.
        #3;
        chk("reset_out", Out1, 0);
        clk_enable = 1'b1; #1; chk_ce("ce_in_reset_hi");
        clk_enable = 1'b0; #1; chk_ce("ce_in_reset_lo");
        repeat (2) @(posedge clk);
        #1;
        chk("reset_held", Out1, 0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) step(1'b1, 16'sd0);

        // Apply the impulse and enable-gating table.
        for (int i = 0; i < 24; i++) begin
            step(tbl[i].en, tbl[i].din);
            chk($sformatf("impulse_vec%0d", i), Out1, tbl[i].exp);
        end

        // Saturation at both rails.
        for (int i = 0; i < 20; i++) step(1'b1, 16'sd32767);
        chk("sat_pos", Out1, 32767);
        for (int i = 0; i < 20; i++) step(1'b1, -16'sd32768);
        chk("sat_neg", Out1, -32768);

        // Full-scale alternation settles to 345 and -347.
        for (int i = 0; i < 20; i++) step(1'b1, (i % 2 == 0) ? 16'sd32767 : -16'sd32768);
        step(1'b1, 16'sd32767);
        chk("alt_pos", Out1, 345);
        step(1'b1, -16'sd32768);
        chk("alt_neg", Out1, -347);

        // Assert reset asynchronously partway through an impulse response.
        for (int i = 0; i < 17; i++) step(1'b1, 16'sd0);
        step(1'b1, 16'sd32767);
        for (int i = 0; i < 7; i++) step(1'b1, 16'sd0);
        chk("mid_impulse_nonzero", Out1, imp[7]);
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset", Out1, 0);
        chk_ce("ce_async_reset");
        model_clear();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 17; i++) begin
            step(1'b1, 16'sd0);
            chk("post_reset_zero", Out1, 0);
        end

        // Random run checked against the model, with the enable mostly high.
        for (int i = 0; i < 400; i++) begin
            logic signed [15:0] r;
            r = 16'($urandom);
            if ($urandom_range(0, 7) == 0) r = ($urandom_range(0, 1) != 0) ? 16'sd32767 : -16'sd32768;
            step($urandom_range(0, 3) != 0, r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
